// File: rtl/stream_fifo_reg.sv
`default_nettype none
// ============================================================================
// Module   : stream_fifo_reg
// Brief    : Valid/ready FIFO with fully registered handshake outputs, fill
//            level, almost-full flag and synchronous flush.
// Revision : 1.0
// ============================================================================
module stream_fifo_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] up_bus,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [DATA_WIDTH-1:0] dn_bus,
  output logic                  dn_val,
  input  logic                  dn_rdy,
  output logic [CNT_W-1:0]      level,
  output logic                  afull
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_PINC  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] dn_bus_q, dn_bus_d;
  logic                  up_rdy_q, dn_val_q, afull_q;
  logic                  push, pop, head_from_up;

  always_comb begin
    push         = up_val & up_rdy_q;
    pop          = dn_val_q & dn_rdy;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dn_bus_d     = dn_bus_q;
    // No older word remains after this edge, so the next head can only be the incoming one
    head_from_up = (level_q == '0) || (pop && (level_q == C_ONE));

    if (push) wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + C_PINC;
    if (pop)  rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + C_PINC;

    case ({push, pop})
      2'b10:   level_d = level_q + C_ONE;
      2'b01:   level_d = level_q - C_ONE;
      default: level_d = level_q;
    endcase

    if (pop || (level_q == '0)) begin
      dn_bus_d = head_from_up ? up_bus : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_rdy_q <= 1'b0;
      dn_val_q <= 1'b0;
      afull_q  <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dn_bus_q <= '0;
    end else if (flush) begin
      up_rdy_q <= 1'b1;
      dn_val_q <= 1'b0;
      afull_q  <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      up_rdy_q <= (level_d != C_DEPTH);
      dn_val_q <= (level_d != '0);
      afull_q  <= (level_d >= C_AFULL);
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dn_bus_q <= dn_bus_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_q[wr_ptr_q] <= up_bus;
    end
  end

  assign up_rdy = up_rdy_q;
  assign dn_val = dn_val_q;
  assign dn_bus = dn_bus_q;
  assign level  = level_q;
  assign afull  = afull_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_fifo_reg
// Brief    : Bench for stream_fifo_reg, DEPTH=4 and DEPTH=3 instances checked
//            against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_stream_fifo_reg;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          up_val = 1'b0;
  logic          dn_rdy = 1'b0;
  logic [DW-1:0] up_bus = '0;
  logic          sel = 1'b0;

  logic          a_up_rdy, a_dn_val, a_afull;
  logic [DW-1:0] a_dn_bus;
  logic [2:0]    a_level;
  logic          b_up_rdy, b_dn_val, b_afull;
  logic [DW-1:0] b_dn_bus;
  logic [1:0]    b_level;

  logic [5:0]    o_status;
  logic [DW-1:0] o_dn_bus;
  logic          o_dn_val, o_up_rdy;
  logic [2:0]    o_level;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of stored words plus the reset flag
  int            depth = 4;
  int            afl = 3;
  logic [DW-1:0] mq[$];
  bit            m_rstd = 1'b1;
  bit            m_push, m_pop;

  always #5 clk = ~clk;

  stream_fifo_reg #(.DATA_WIDTH(DW), .DEPTH(4)) u_dut_d4 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_bus(up_bus), .up_val(up_val), .up_rdy(a_up_rdy),
    .dn_bus(a_dn_bus), .dn_val(a_dn_val), .dn_rdy(dn_rdy),
    .level(a_level), .afull(a_afull)
  );

  stream_fifo_reg #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut_d3 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_bus(up_bus), .up_val(up_val), .up_rdy(b_up_rdy),
    .dn_bus(b_dn_bus), .dn_val(b_dn_val), .dn_rdy(dn_rdy),
    .level(b_level), .afull(b_afull)
  );

  assign o_status = sel ? {b_up_rdy, b_dn_val, b_afull, 1'b0, b_level}
                        : {a_up_rdy, a_dn_val, a_afull, a_level};
  assign o_dn_bus = sel ? b_dn_bus : a_dn_bus;
  assign o_dn_val = sel ? b_dn_val : a_dn_val;
  assign o_up_rdy = sel ? b_up_rdy : a_up_rdy;
  assign o_level  = sel ? {1'b0, b_level} : a_level;

  // {up_rdy, dn_val, afull, level[2:0]} as the model predicts them
  function automatic logic [5:0] exp_status();
    int   n;
    logic r, v, f;
    n = mq.size();
    r = !m_rstd && (n != depth);
    v = (n != 0);
    f = (n >= afl);
    return {r, v, f, n[2:0]};
  endfunction

  // Advance one clock and update the model; outputs are settled on return
  task automatic step();
    m_push = up_val && !m_rstd && (mq.size() != depth);
    m_pop  = (mq.size() != 0) && dn_rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_rstd = 1'b1;
      m_push = 1'b0;
      m_pop  = 1'b0;
    end else begin
      m_rstd = 1'b0;
      if (flush) begin
        mq.delete();
        m_push = 1'b0;
        m_pop  = 1'b0;
      end else begin
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(up_bus);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_status !== 6'b000000) begin
        errors++;
        $display("FAIL reset_state: got %b want %b", o_status, 6'b000000);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (o_status !== 6'b100000) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", o_status, 6'b100000);
    end
  endtask

  task automatic test_stream();
    dn_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_val = 1'b1;
      up_bus = DW'(i);
      step();
      checks++;
      if (o_status !== exp_status() || o_level !== 3'd1) begin
        errors++;
        $display("FAIL stream_status[%0d]: got %b want %b", i, o_status, exp_status());
      end
      checks++;
      if (o_dn_bus !== DW'(i)) begin
        errors++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, o_dn_bus, DW'(i));
      end
    end
    up_val = 1'b0;
    step();
    checks++;
    if (o_status !== exp_status()) begin
      errors++;
      $display("FAIL stream_drain: got %b want %b", o_status, exp_status());
    end
  endtask

  task automatic test_fill();
    int            idx;
    bit            first;
    logic [DW-1:0] got[$];
    idx    = 0;
    dn_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      up_val = (idx < 6);
      up_bus = 32'hA0 + DW'(idx);
      step();
      if (m_push) idx++;
      checks++;
      if (o_status !== exp_status() || (mq.size() != 0 && o_dn_bus !== mq[0])) begin
        errors++;
        $display("FAIL fill_cycle[%0d]: got %b/%h want %b", c, o_status, o_dn_bus, exp_status());
      end
    end
    checks++;
    if (idx != 4 || o_status !== 6'b011100 || o_dn_bus !== 32'hA0) begin
      errors++;
      $display("FAIL fill_full: got acc=%0d st=%b bus=%h want acc=4 st=011100 bus=a0",
               idx, o_status, o_dn_bus);
    end
    dn_rdy = 1'b1;
    first  = 1'b1;
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      up_val = (idx < 6);
      up_bus = 32'hA0 + DW'(idx);
      if (o_dn_val && dn_rdy) got.push_back(o_dn_bus);
      step();
      if (m_push) idx++;
      if (first) begin
        first = 1'b0;
        checks++;
        if (o_up_rdy !== 1'b1) begin
          errors++;
          $display("FAIL fill_rdy_return: got %b want 1", o_up_rdy);
        end
      end
      checks++;
      if (o_status !== exp_status() || (mq.size() != 0 && o_dn_bus !== mq[0])) begin
        errors++;
        $display("FAIL fill_drain[%0d]: got %b/%h want %b", c, o_status, o_dn_bus, exp_status());
      end
    end
    up_val = 1'b0;
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL fill_count: got %0d want 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== 32'hA0 + DW'(i)) begin
          errors++;
          $display("FAIL fill_order[%0d]: got %h want %h", i, got[i], 32'hA0 + DW'(i));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    dn_rdy = 1'b0;
    up_val = 1'b1;
    up_bus = 32'h11;
    step();
    up_bus = 32'h22;
    step();
    up_bus = 32'h55;
    dn_rdy = 1'b1;
    step();
    checks++;
    if (o_level !== 3'd2 || o_dn_bus !== 32'h22 || o_status !== exp_status()) begin
      errors++;
      $display("FAIL simul_pushpop: got lvl=%0d bus=%h want lvl=2 bus=22", o_level, o_dn_bus);
    end
    up_val = 1'b0;
    step();
    checks++;
    if (o_level !== 3'd1 || o_dn_bus !== 32'h55 || o_status !== exp_status()) begin
      errors++;
      $display("FAIL simul_next: got lvl=%0d bus=%h want lvl=1 bus=55", o_level, o_dn_bus);
    end
    step();
    checks++;
    if (o_status !== exp_status()) begin
      errors++;
      $display("FAIL simul_empty: got %b want %b", o_status, exp_status());
    end
  endtask

  task automatic test_flush();
    dn_rdy = 1'b0;
    up_val = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      up_bus = 32'hC0 + DW'(i);
      step();
    end
    checks++;
    if (o_status !== 6'b111011) begin
      errors++;
      $display("FAIL flush_pre: got %b want %b", o_status, 6'b111011);
    end
    flush  = 1'b1;
    up_bus = 32'h77;
    dn_rdy = 1'b1;
    step();
    flush  = 1'b0;
    up_val = 1'b0;
    checks++;
    if (o_status !== 6'b100000) begin
      errors++;
      $display("FAIL flush_state: got %b want %b", o_status, 6'b100000);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_dn_val !== 1'b0 || o_status !== exp_status()) begin
        errors++;
        $display("FAIL flush_no_data[%0d]: got val=%b bus=%h want val=0", i, o_dn_val, o_dn_bus);
      end
    end
  endtask

  task automatic test_reset_mid();
    dn_rdy = 1'b0;
    up_val = 1'b1;
    up_bus = 32'hD1;
    step();
    up_bus = 32'hD2;
    step();
    checks++;
    if (o_level !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: got lvl=%0d want 2", o_level);
    end
    rst    = 1'b1;
    up_bus = 32'h99;
    dn_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_status !== 6'b000000) begin
        errors++;
        $display("FAIL rstmid_during[%0d]: got %b want %b", i, o_status, 6'b000000);
      end
    end
    rst    = 1'b0;
    up_val = 1'b0;
    step();
    checks++;
    if (o_status !== 6'b100000) begin
      errors++;
      $display("FAIL rstmid_release: got %b want %b", o_status, 6'b100000);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_dn_val !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale[%0d]: got val=%b bus=%h want val=0", i, o_dn_val, o_dn_bus);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    int            k;
    bit            bad;
    sel   = 1'b1;
    depth = 3;
    afl   = 2;
    rst   = 1'b1;
    up_val = 1'b0;
    dn_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) sent.push_back(DW'($urandom));
    k = 0;
    for (int c = 0; c < 400 && got.size() < 20; c++) begin
      if (!up_val) up_val = (k < 20) && ($urandom_range(0, 3) != 0);
      up_bus = (k < 20) ? sent[k] : '0;
      dn_rdy = 1'($urandom_range(0, 1));
      if (o_dn_val && dn_rdy) got.push_back(o_dn_bus);
      step();
      if (m_push) begin
        k++;
        up_val = (k < 20) && ($urandom_range(0, 3) != 0);
      end
      checks++;
      if (o_status !== exp_status() || o_level > 3'd3 ||
          (mq.size() != 0 && o_dn_bus !== mq[0])) begin
        errors++;
        $display("FAIL wrap_cycle[%0d]: got %b/%h want %b", c, o_status, o_dn_bus, exp_status());
      end
    end
    up_val = 1'b0;
    checks++;
    if (got.size() != 20) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 20 (cycle budget)", got.size());
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 20; i++) if (got[i] !== sent[i]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL wrap_order: got first %h last %h want %h %h", got[0], got[19], sent[0], sent[19]);
      end
    end
  endtask

  initial begin
    void'($urandom(32'h5EED));
    test_reset();
    test_stream();
    test_fill();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
